// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// The memory FSM encoding is fixed so that state dumps stay comparable with older builds.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_RESUME    = 2'd3
  } state_e;

  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W   = 32;
  localparam int unsigned MISS_CNT_W  = 16;

  // True while an off-chip transaction is outstanding.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_WRITEBACK) || (s == ST_REFILL);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline control and off-chip memory handshake bundle for pipeline_stall_ctrl.
// master = the controller, slave = pipeline/memory side.
interface pipeline_stall_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic                  hazard_stall_i;
  logic                  branch_taken_i;
  logic                  dcache_miss_i;
  logic                  dcache_dirty_i;
  logic                  mem_ack_i;
  logic                  PCWrite_o;
  logic                  IFID_Write_o;
  logic                  IFID_Flush_o;
  logic                  IDEX_NoOp_o;
  logic                  Freeze_o;
  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic                  refill_o;
  logic                  err_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [MISS_CNT_W-1:0] miss_cnt_o;

  modport master (
    input  hazard_stall_i, branch_taken_i, dcache_miss_i, dcache_dirty_i, mem_ack_i,
    output PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_NoOp_o, Freeze_o,
           mem_enable_o, mem_write_o, refill_o, err_o, stall_cnt_o, miss_cnt_o
  );

  modport slave (
    output hazard_stall_i, branch_taken_i, dcache_miss_i, dcache_dirty_i, mem_ack_i,
    input  PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_NoOp_o, Freeze_o,
           mem_enable_o, mem_write_o, refill_o, err_o, stall_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Merges load-use, branch-flush and data-cache-miss stalls into per-stage controls
// and sequences the cache write-back/refill handshake with off-chip memory.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_stall_ctrl_if.master bus
);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            mem_enable_q, mem_enable_d;
  logic            mem_write_q, mem_write_d;
  logic            refill_q, refill_d;
  logic            mem_stall;
  logic            pc_write;
  logic            miss_accept;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.dcache_miss_i) state_d = bus.dcache_dirty_i ? ST_WRITEBACK : ST_REFILL;
      ST_WRITEBACK: if (bus.mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:    if (bus.mem_ack_i) state_d = ST_RESUME;
      ST_RESUME:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Watchdog restarts on every memory-state entry and only advances while the
    // FSM is still waiting for an ack in the same state.
    wdog_d = wdog_q;
    if (is_mem_state(state_d) && (state_d != state_q))
      wdog_d = '0;
    else if (is_mem_state(state_q) && (state_d == state_q) && (wdog_q != WD_MAX))
      wdog_d = wdog_q + 1'b1;

    err_d = err_q | (wdog_d == WD_MAX);

    // Memory outputs are registered from the next state so they decode state only.
    mem_enable_d = is_mem_state(state_d);
    mem_write_d  = (state_d == ST_WRITEBACK);
    refill_d     = (state_d == ST_RESUME);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wdog_q       <= '0;
      err_q        <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      refill_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      refill_q     <= refill_d;
    end
  end

  // Priority: memory freeze, then load-use bubble, then branch flush.
  assign mem_stall   = (state_q != ST_IDLE) | bus.dcache_miss_i;
  assign pc_write    = ~(mem_stall | bus.hazard_stall_i);
  assign miss_accept = (state_q == ST_IDLE) & bus.dcache_miss_i;

  assign bus.Freeze_o     = mem_stall;
  assign bus.PCWrite_o    = pc_write;
  assign bus.IFID_Write_o = pc_write;
  assign bus.IDEX_NoOp_o  = bus.hazard_stall_i & ~mem_stall;
  assign bus.IFID_Flush_o = bus.branch_taken_i & ~bus.hazard_stall_i & ~mem_stall;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.refill_o     = refill_q;
  assign bus.err_o        = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (~pc_write),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_counter #(.W(MISS_CNT_W)) u_miss_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (miss_accept),
    .cnt_o (bus.miss_cnt_o)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a transaction-level model queues the
// expected outputs per cycle; a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 4;
  localparam int PH_WB = 1, PH_RD = 2, PH_RS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();
  pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]    ctl;
    logic [2:0]    mem;
    logic          err;
    logic [CW-1:0] stall;
    logic [15:0]   miss;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: outstanding memory phases as a queue of work items.
  int          phases[$];
  int unsigned m_wait  = 0;
  bit          m_err   = 0;
  int unsigned m_stall = 0;
  int unsigned m_miss  = 0;
  bit          m_valid = 0;
  bit p_h = 0, p_b = 0, p_m = 0, p_d = 0, p_a = 0, p_r = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit h, input bit b, input bit m, input bit d, input bit a, input bit r);
    bit   busy, pcw;
    exp_t e;
    @(posedge clk);
    #1;
    if (p_r) begin
      phases.delete();
      m_wait = 0; m_err = 0; m_stall = 0; m_miss = 0; m_valid = 1;
    end else if (m_valid) begin
      busy = (phases.size() != 0) || p_m;
      if ((busy || p_h) && (m_stall < (2**CW - 1))) m_stall++;
      if (phases.size() == 0) begin
        if (p_m) begin
          if (m_miss < 65535) m_miss++;
          if (p_d) phases.push_back(PH_WB);
          phases.push_back(PH_RD);
          phases.push_back(PH_RS);
          m_wait = 0;
        end
      end else if (phases[0] == PH_RS) begin
        void'(phases.pop_front());
      end else if (p_a) begin
        void'(phases.pop_front());
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait >= TO) m_err = 1;
      end
    end

    bus.hazard_stall_i = h; bus.branch_taken_i = b; bus.dcache_miss_i = m;
    bus.dcache_dirty_i = d; bus.mem_ack_i = a; rst = r;
    p_h = h; p_b = b; p_m = m; p_d = d; p_a = a; p_r = r;

    if (m_valid) begin
      busy    = (phases.size() != 0) || m;
      pcw     = !(busy || h);
      e.ctl   = {pcw, pcw, b & !h & !busy, h & !busy, busy};
      e.mem   = 3'b000;
      if (phases.size() != 0)
        e.mem = {phases[0] != PH_RS, phases[0] == PH_WB, phases[0] == PH_RS};
      e.err   = m_err;
      e.stall = m_stall[CW-1:0];
      e.miss  = m_miss[15:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ctl{pcw,ifidw,flush,noop,freeze}",
            {27'd0, bus.PCWrite_o, bus.IFID_Write_o, bus.IFID_Flush_o, bus.IDEX_NoOp_o, bus.Freeze_o},
            {27'd0, e.ctl});
      check("mem{enable,write,refill}",
            {29'd0, bus.mem_enable_o, bus.mem_write_o, bus.refill_o}, {29'd0, e.mem});
      check("err", {31'd0, bus.err_o}, {31'd0, e.err});
      check("stall_cnt", {{(32-CW){1'b0}}, bus.stall_cnt_o}, {{(32-CW){1'b0}}, e.stall});
      check("miss_cnt", {16'd0, bus.miss_cnt_o}, {16'd0, e.miss});
    end
  end

  initial begin
    rst = 1;
    bus.hazard_stall_i = 0; bus.branch_taken_i = 0; bus.dcache_miss_i = 0;
    bus.dcache_dirty_i = 0; bus.mem_ack_i = 0;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    idle(2);
    // load-use alone, then load-use with branch, then branch alone
    cycle(1, 0, 0, 0, 0, 0);
    idle(1);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    idle(2);
    // clean miss, ack five cycles after mem_enable rises
    cycle(0, 0, 1, 0, 0, 0);
    idle(4);
    cycle(0, 0, 0, 0, 1, 0);
    idle(3);
    // dirty miss, acks at latency 3 and 4
    cycle(0, 0, 1, 1, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 1, 0);
    idle(3);
    cycle(0, 0, 0, 0, 1, 0);
    idle(3);
    // watchdog: no ack well past TIMEOUT, then a late ack still finishes
    cycle(0, 0, 1, 0, 0, 0);
    idle(TO + 6);
    cycle(0, 0, 0, 0, 1, 0);
    idle(4);
    // reset mid write-back; the following ack must be ignored
    cycle(0, 0, 1, 1, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
            $urandom_range(0, 1) == 1, ($urandom % 3) == 0, ($urandom % 250) == 0);
    idle(3);
    @(posedge clk);
    #6;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
